// File: rtl/valid_array_ctrl_pkg.sv
// Shared types for the valid-bit array controller: flush walker states and issued-operation codes.
package valid_array_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StDone
  } flush_state_e;

  typedef enum logic [2:0] {
    OpNone,
    OpLookup,
    OpFill,
    OpInval,
    OpFlush
  } array_op_e;

endpackage

// File: rtl/find_first_zero_onehot.sv
// One-hot of the lowest-index zero bit in vec, plus a flag when vec has no zero bit.
module find_first_zero_onehot #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] onehot,
  output logic             all_ones
);

  // Adding one ripples through the trailing ones and sets exactly the lowest zero.
  assign onehot   = ~vec & (vec + WIDTH'(1));
  assign all_ones = &vec;

endmodule

// File: rtl/valid_array_controller.sv
// Arbiter/sequencer in front of a per-set, per-way valid-bit array.
// Optional flush walker is built only when VALID_ARRAY_CTRL_FLUSH_EN is defined.
module valid_array_controller
  import valid_array_ctrl_pkg::*;
#(
  parameter int unsigned NUMBER_SET            = 64,
  parameter int unsigned NUMBER_WAY            = 16,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SET)
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             lookup_valid_in,
  output logic                             lookup_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] lookup_set_in,
  output logic                             lookup_done_out,
  output logic [NUMBER_WAY-1:0]            lookup_valid_vec_out,
  output logic [NUMBER_WAY-1:0]            lookup_victim_way_out,
  input  logic                             fill_valid_in,
  output logic                             fill_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] fill_set_in,
  input  logic [NUMBER_WAY-1:0]            fill_way_in,
  input  logic                             inval_valid_in,
  output logic                             inval_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] inval_set_in,
  input  logic [NUMBER_WAY-1:0]            inval_way_in,
  input  logic                             flush_req_in,
  output logic                             flush_busy_out,
  output logic                             flush_done_out,
  output logic                             array_access_en_out,
  output logic                             array_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0] array_set_addr_out,
  output logic [NUMBER_WAY-1:0]            array_way_mask_out,
  output logic [NUMBER_WAY-1:0]            array_write_data_out,
  input  logic [NUMBER_WAY-1:0]            array_read_valid_in
);

  localparam int unsigned RrWidth = (NUMBER_WAY > 1) ? $clog2(NUMBER_WAY) : 1;

  logic                             flush_active;
  logic                             flush_blocking;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] flush_set;

`ifdef VALID_ARRAY_CTRL_FLUSH_EN
  flush_state_e                     state_q;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] flush_cnt_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_req_in) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
          end
        end
        StFlush: begin
          // Terminal compare, not wrap, so non-power-of-two set counts work.
          if (flush_cnt_q == SET_PTR_WIDTH_IN_BITS'(NUMBER_SET - 1)) begin
            state_q <= StDone;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign flush_active   = (state_q == StFlush);
  assign flush_blocking = ((state_q == StIdle) && flush_req_in) || flush_active;
  assign flush_set      = flush_cnt_q;
  assign flush_busy_out = flush_active;
  assign flush_done_out = (state_q == StDone);
`else
  logic unused_flush_req;
  assign unused_flush_req = flush_req_in;
  assign flush_active     = 1'b0;
  assign flush_blocking   = 1'b0;
  assign flush_set        = '0;
  assign flush_busy_out   = 1'b0;
  assign flush_done_out   = 1'b0;
`endif

  assign inval_ready_out  = !flush_blocking;
  assign fill_ready_out   = !flush_blocking && !inval_valid_in;
  assign lookup_ready_out = !flush_blocking && !inval_valid_in && !fill_valid_in;

  array_op_e op;

  always_comb begin
    op = OpNone;
    if (flush_active) begin
      op = OpFlush;
    end else if (!flush_blocking) begin
      if (inval_valid_in)       op = OpInval;
      else if (fill_valid_in)   op = OpFill;
      else if (lookup_valid_in) op = OpLookup;
    end
  end

  always_comb begin
    array_access_en_out  = 1'b0;
    array_write_en_out   = 1'b0;
    array_set_addr_out   = '0;
    array_way_mask_out   = '0;
    array_write_data_out = '0;
    unique case (op)
      OpLookup: begin
        array_access_en_out = 1'b1;
        array_set_addr_out  = lookup_set_in;
        array_way_mask_out  = '1;
      end
      OpFill: begin
        array_access_en_out  = 1'b1;
        array_write_en_out   = 1'b1;
        array_set_addr_out   = fill_set_in;
        array_way_mask_out   = fill_way_in;
        array_write_data_out = '1;
      end
      OpInval: begin
        array_access_en_out = 1'b1;
        array_write_en_out  = 1'b1;
        array_set_addr_out  = inval_set_in;
        array_way_mask_out  = inval_way_in;
      end
      OpFlush: begin
        array_access_en_out = 1'b1;
        array_write_en_out  = 1'b1;
        array_set_addr_out  = flush_set;
        array_way_mask_out  = '1;
      end
      default: ;
    endcase
  end

  logic [NUMBER_WAY-1:0] first_zero;
  logic                  set_full;
  logic [NUMBER_WAY-1:0] victim_now;

  find_first_zero_onehot #(
    .WIDTH (NUMBER_WAY)
  ) u_victim_ffz (
    .vec      (array_read_valid_in),
    .onehot   (first_zero),
    .all_ones (set_full)
  );

  logic [RrWidth-1:0]    rr_q;
  logic                  done_q;
  logic [NUMBER_WAY-1:0] vec_q;
  logic [NUMBER_WAY-1:0] victim_q;

  assign victim_now = set_full ? (NUMBER_WAY'(1) << rr_q) : first_zero;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rr_q     <= '0;
      done_q   <= 1'b0;
      vec_q    <= '0;
      victim_q <= '0;
    end else begin
      done_q <= (op == OpLookup);
      if (op == OpFill) begin
        rr_q <= (rr_q == RrWidth'(NUMBER_WAY - 1)) ? '0 : rr_q + 1'b1;
      end
      if (done_q) begin
        vec_q    <= array_read_valid_in;
        victim_q <= victim_now;
      end
    end
  end

  // Array read data arrives in the response cycle; hold it afterwards.
  assign lookup_done_out       = done_q;
  assign lookup_valid_vec_out  = done_q ? array_read_valid_in : vec_q;
  assign lookup_victim_way_out = done_q ? victim_now : victim_q;

endmodule

// File: tb/tb_valid_array_controller.sv
// Directed self-checking bench for valid_array_controller with a behavioural valid-bit array.
module tb_valid_array_controller;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        lookup_valid_in, lookup_ready_out, lookup_done_out;
  logic [5:0]  lookup_set_in;
  logic [15:0] lookup_valid_vec_out, lookup_victim_way_out;
  logic        fill_valid_in, fill_ready_out;
  logic [5:0]  fill_set_in;
  logic [15:0] fill_way_in;
  logic        inval_valid_in, inval_ready_out;
  logic [5:0]  inval_set_in;
  logic [15:0] inval_way_in;
  logic        flush_req_in, flush_busy_out, flush_done_out;
  logic        array_access_en_out, array_write_en_out;
  logic [5:0]  array_set_addr_out;
  logic [15:0] array_way_mask_out, array_write_data_out;
  logic [15:0] array_read_valid_in;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  valid_array_controller dut (
    .clk_in                (clk_in),
    .reset_in              (reset_in),
    .lookup_valid_in       (lookup_valid_in),
    .lookup_ready_out      (lookup_ready_out),
    .lookup_set_in         (lookup_set_in),
    .lookup_done_out       (lookup_done_out),
    .lookup_valid_vec_out  (lookup_valid_vec_out),
    .lookup_victim_way_out (lookup_victim_way_out),
    .fill_valid_in         (fill_valid_in),
    .fill_ready_out        (fill_ready_out),
    .fill_set_in           (fill_set_in),
    .fill_way_in           (fill_way_in),
    .inval_valid_in        (inval_valid_in),
    .inval_ready_out       (inval_ready_out),
    .inval_set_in          (inval_set_in),
    .inval_way_in          (inval_way_in),
    .flush_req_in          (flush_req_in),
    .flush_busy_out        (flush_busy_out),
    .flush_done_out        (flush_done_out),
    .array_access_en_out   (array_access_en_out),
    .array_write_en_out    (array_write_en_out),
    .array_set_addr_out    (array_set_addr_out),
    .array_way_mask_out    (array_way_mask_out),
    .array_write_data_out  (array_write_data_out),
    .array_read_valid_in   (array_read_valid_in)
  );

  // Behavioural array: read returns pre-write contents one cycle later, junk when idle.
  logic [15:0] mem [64];
  initial for (int s = 0; s < 64; s++) mem[s] = 16'h0;

  always @(posedge clk_in) begin
    if (array_access_en_out) begin
      array_read_valid_in <= mem[array_set_addr_out];
      if (array_write_en_out) begin
        mem[array_set_addr_out] <= (mem[array_set_addr_out] & ~array_way_mask_out) |
                                   (array_write_data_out & array_way_mask_out);
      end
    end else begin
      array_read_valid_in <= 16'hA5A5;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic [15:0] vec, input logic [15:0] vic);
    check({tag, "_done"}, 32'(lookup_done_out), 32'd1);
    check({tag, "_vec"}, 32'(lookup_valid_vec_out), 32'(vec));
    check({tag, "_victim"}, 32'(lookup_victim_way_out), 32'(vic));
  endtask

  initial begin
    logic all_zero;
    reset_in        = 1'b1;
    lookup_valid_in = 1'b0; lookup_set_in = '0;
    fill_valid_in   = 1'b0; fill_set_in   = '0; fill_way_in  = '0;
    inval_valid_in  = 1'b0; inval_set_in  = '0; inval_way_in = '0;
    flush_req_in    = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    #1;
    check("rst_done", 32'(lookup_done_out), 32'd0);
    check("rst_vec", 32'(lookup_valid_vec_out), 32'd0);
    check("rst_victim", 32'(lookup_victim_way_out), 32'd0);
    check("rst_busy", 32'(flush_busy_out), 32'd0);
    check("rst_fdone", 32'(flush_done_out), 32'd0);
    check("rst_access", 32'(array_access_en_out), 32'd0);
    check("rst_lkrdy", 32'(lookup_ready_out), 32'd1);

    // Lookup set 5 on empty array.
    @(negedge clk_in);
    lookup_valid_in = 1'b1; lookup_set_in = 6'd5;
    #1;
    check("lk_access", 32'(array_access_en_out), 32'd1);
    check("lk_wr", 32'(array_write_en_out), 32'd0);
    check("lk_addr", 32'(array_set_addr_out), 32'd5);
    check("lk_mask", 32'(array_way_mask_out), 32'hFFFF);
    @(negedge clk_in);
    lookup_valid_in = 1'b0;
    #1;
    check_resp("lk_empty", 16'h0000, 16'h0001);
    @(negedge clk_in);
    #1;
    check("lk_pulse_end", 32'(lookup_done_out), 32'd0);

    // Fill all 16 ways of set 5.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      fill_valid_in = 1'b1; fill_set_in = 6'd5; fill_way_in = 16'(1) << i;
      #1;
      if (i == 3) begin
        check("fill_rdy", 32'(fill_ready_out), 32'd1);
        check("fill_wr", 32'(array_write_en_out), 32'd1);
        check("fill_mask", 32'(array_way_mask_out), 32'h0008);
        check("fill_data", 32'(array_write_data_out), 32'hFFFF);
      end
    end
    @(negedge clk_in);
    fill_valid_in = 1'b0; lookup_valid_in = 1'b1; lookup_set_in = 6'd5;
    @(negedge clk_in);
    lookup_valid_in = 1'b0;
    #1;
    check_resp("lk_full_rr0", 16'hFFFF, 16'h0001);
    @(negedge clk_in);
    #1;
    check("hold_done", 32'(lookup_done_out), 32'd0);
    check("hold_vec", 32'(lookup_valid_vec_out), 32'hFFFF);
    check("hold_victim", 32'(lookup_victim_way_out), 32'h0001);

    // One more fill advances the pointer to 1.
    fill_valid_in = 1'b1; fill_set_in = 6'd5; fill_way_in = 16'h0001;
    @(negedge clk_in);
    fill_valid_in = 1'b0; lookup_valid_in = 1'b1; lookup_set_in = 6'd5;
    @(negedge clk_in);
    lookup_valid_in = 1'b0;
    #1;
    check_resp("lk_full_rr1", 16'hFFFF, 16'h0002);

    // Invalidate ways 4..7 of set 5.
    @(negedge clk_in);
    inval_valid_in = 1'b1; inval_set_in = 6'd5; inval_way_in = 16'h00F0;
    #1;
    check("inv_wr", 32'(array_write_en_out), 32'd1);
    check("inv_mask", 32'(array_way_mask_out), 32'h00F0);
    check("inv_data", 32'(array_write_data_out), 32'h0000);
    @(negedge clk_in);
    inval_valid_in = 1'b0; lookup_valid_in = 1'b1; lookup_set_in = 6'd5;
    @(negedge clk_in);
    lookup_valid_in = 1'b0;
    #1;
    check_resp("lk_after_inv", 16'hFF0F, 16'h0010);

    // Inval, fill and lookup presented together: served in priority order.
    @(negedge clk_in);
    inval_valid_in  = 1'b1; inval_set_in  = 6'd7; inval_way_in = 16'h0001;
    fill_valid_in   = 1'b1; fill_set_in   = 6'd7; fill_way_in  = 16'h0004;
    lookup_valid_in = 1'b1; lookup_set_in = 6'd7;
    #1;
    check("pri_inv_rdy", 32'(inval_ready_out), 32'd1);
    check("pri_fill_rdy0", 32'(fill_ready_out), 32'd0);
    check("pri_lk_rdy0", 32'(lookup_ready_out), 32'd0);
    check("pri_inv_data", 32'(array_write_data_out), 32'h0000);
    @(negedge clk_in);
    inval_valid_in = 1'b0;
    #1;
    check("pri_fill_rdy1", 32'(fill_ready_out), 32'd1);
    check("pri_lk_rdy1", 32'(lookup_ready_out), 32'd0);
    check("pri_fill_mask", 32'(array_way_mask_out), 32'h0004);
    @(negedge clk_in);
    fill_valid_in = 1'b0;
    #1;
    check("pri_lk_rdy2", 32'(lookup_ready_out), 32'd1);
    check("pri_lk_wr", 32'(array_write_en_out), 32'd0);
    @(negedge clk_in);
    lookup_valid_in = 1'b0;
    #1;
    check_resp("pri_lk", 16'h0004, 16'h0001);

    // Fill right after lookup of the same set: response shows pre-fill contents.
    @(negedge clk_in);
    lookup_valid_in = 1'b1; lookup_set_in = 6'd9;
    @(negedge clk_in);
    lookup_valid_in = 1'b0;
    fill_valid_in = 1'b1; fill_set_in = 6'd9; fill_way_in = 16'h0001;
    #1;
    check_resp("lk_prefill", 16'h0000, 16'h0001);
    @(negedge clk_in);
    fill_valid_in = 1'b0; lookup_valid_in = 1'b1; lookup_set_in = 6'd9;
    @(negedge clk_in);
    lookup_valid_in = 1'b0;
    #1;
    check_resp("lk_postfill", 16'h0001, 16'h0002);

`ifdef VALID_ARRAY_CTRL_FLUSH_EN
    // Flush with a lookup response in flight and a lookup stalled throughout.
    @(negedge clk_in);
    lookup_valid_in = 1'b1; lookup_set_in = 6'd9;
    @(negedge clk_in);
    flush_req_in = 1'b1;
    #1;
    check_resp("lk_over_flush", 16'h0001, 16'h0002);
    check("fl_req_lkrdy", 32'(lookup_ready_out), 32'd0);
    check("fl_req_access", 32'(array_access_en_out), 32'd0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_in);
      flush_req_in = 1'b0;
      #1;
      check("fl_busy", 32'(flush_busy_out), 32'd1);
      check("fl_addr", 32'(array_set_addr_out), 32'(k));
      check("fl_wr", 32'(array_write_en_out), 32'd1);
      check("fl_mask", 32'(array_way_mask_out), 32'hFFFF);
      check("fl_data", 32'(array_write_data_out), 32'h0000);
      check("fl_lkrdy", 32'(lookup_ready_out), 32'd0);
      check("fl_invrdy", 32'(inval_ready_out), 32'd0);
      check("fl_fdone", 32'(flush_done_out), 32'd0);
    end
    @(negedge clk_in);
    #1;
    check("fl_done", 32'(flush_done_out), 32'd1);
    check("fl_done_busy", 32'(flush_busy_out), 32'd0);
    check("fl_done_lkrdy", 32'(lookup_ready_out), 32'd1);
    check("fl_done_addr", 32'(array_set_addr_out), 32'd9);
    @(negedge clk_in);
    lookup_valid_in = 1'b0;
    #1;
    check("fl_done_pulse", 32'(flush_done_out), 32'd0);
    check_resp("lk_post_flush", 16'h0000, 16'h0001);
    all_zero = 1'b1;
    for (int s = 0; s < 64; s++) if (mem[s] !== 16'h0) all_zero = 1'b0;
    check("fl_all_sets_zero", 32'(all_zero), 32'd1);

    // Reset while the walker is on set 10.
    @(negedge clk_in);
    fill_valid_in = 1'b1; fill_set_in = 6'd11; fill_way_in = 16'h0001;
    @(negedge clk_in);
    fill_valid_in = 1'b0; flush_req_in = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk_in);
      flush_req_in = 1'b0;
      #1;
      check("rfl_addr", 32'(array_set_addr_out), 32'(k));
      if (k == 10) reset_in = 1'b1;
    end
    @(negedge clk_in);
    reset_in = 1'b0;
    #1;
    check("rfl_busy", 32'(flush_busy_out), 32'd0);
    check("rfl_access", 32'(array_access_en_out), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      #1;
      check("rfl_nodone", 32'(flush_done_out), 32'd0);
      check("rfl_noaccess", 32'(array_access_en_out), 32'd0);
    end
    check("rfl_set11_kept", 32'(mem[11]), 32'h0001);
`else
    // Without the flush walker the request line has no effect.
    @(negedge clk_in);
    flush_req_in = 1'b1; lookup_valid_in = 1'b1; lookup_set_in = 6'd9;
    #1;
    check("nf_lkrdy", 32'(lookup_ready_out), 32'd1);
    check("nf_access", 32'(array_access_en_out), 32'd1);
    check("nf_busy", 32'(flush_busy_out), 32'd0);
    @(negedge clk_in);
    lookup_valid_in = 1'b0;
    #1;
    check_resp("nf_lk", 16'h0001, 16'h0002);
    check("nf_busy2", 32'(flush_busy_out), 32'd0);
    check("nf_fdone", 32'(flush_done_out), 32'd0);
    flush_req_in = 1'b0;
`endif

    @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
